// File: rtl/half_adder_pkg.sv
// Shared defaults and the saturating-increment helper for the half_adder slice.
package half_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;
  localparam int MAX_CNT_W     = 64;

  // Counters up to MAX_CNT_W bits are zero-extended into this helper and truncated back.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                   input int unsigned          width);
    logic [MAX_CNT_W-1:0] max_val;
    max_val = (width >= MAX_CNT_W) ? '1
                                   : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
    return (value >= max_val) ? max_val : value + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/half_adder_if.sv
// Operand/result handshake bundle for half_adder.
// The parity signal exists only when HALF_ADDER_PARITY_EN is defined.
interface half_adder_if import half_adder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic             carry_any;
  logic [CNT_W-1:0] carry_cnt;
  logic             cnt_clr;
`ifdef HALF_ADDER_PARITY_EN
  logic             parity;
`endif

  modport master (
    output in_valid, a, b, out_ready, cnt_clr,
`ifdef HALF_ADDER_PARITY_EN
    input  parity,
`endif
    input  in_ready, out_valid, s, c, carry_any, carry_cnt
  );

  modport slave (
    input  in_valid, a, b, out_ready, cnt_clr,
`ifdef HALF_ADDER_PARITY_EN
    output parity,
`endif
    output in_ready, out_valid, s, c, carry_any, carry_cnt
  );

endinterface

// File: rtl/half_adder_cnt.sv
// Saturating event counter with a synchronous clear that takes priority over increment.
module half_adder_cnt import half_adder_pkg::*; #(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= CNT_W'(sat_inc(MAX_CNT_W'(cnt_q), CNT_W));
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/half_adder.sv
// Registered lane-parallel half adder with a one-entry valid/ready stage and carry-event counter.
// Define HALF_ADDER_PARITY_EN to add a registered parity (XOR of all sums) output.
module half_adder import half_adder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  half_adder_if.slave   bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic             carry_any_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             accept;

  assign sum_d    = bus.a ^ bus.b;
  assign carry_d  = bus.a & bus.b;
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & bus.in_ready;

  // A new accept overwrites the held result; a drain without accept only drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_q         <= '0;
      carry_any_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      s_q         <= sum_d;
      c_q         <= carry_d;
      carry_any_q <= |carry_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.carry_any = carry_any_q;

`ifdef HALF_ADDER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^sum_d;
    end
  end

  assign bus.parity = parity_q;
`endif

  half_adder_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.cnt_clr),
    .inc   (accept & (|carry_d)),
    .cnt   (bus.carry_cnt)
  );

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: a WIDTH=1 instance for the truth table and a
// WIDTH=4/CNT_W=2 instance for handshake, saturation, reset and randomized checks.
module tb_half_adder;

  logic clk;
  logic rst_n;

  int n_compared;
  int n_mismatched;

  half_adder_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  half_adder_if #(.WIDTH(4), .CNT_W(2))  if4 ();

  half_adder #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  half_adder #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic c;
    int   cnt;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] a, input logic [3:0] b,
                               input logic out_ready, input logic clr);
    if4.in_valid  = valid;
    if4.a         = a;
    if4.b         = b;
    if4.out_ready = out_ready;
    if4.cnt_clr   = clr;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    if1.in_valid  = 1'b0;
    if1.a         = 1'b0;
    if1.b         = 1'b0;
    if1.out_ready = 1'b1;
    if1.cnt_clr   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst out_valid", 32'(if4.out_valid), 32'd0);
    checkOutput("rst s", 32'(if4.s), 32'd0);
    checkOutput("rst c", 32'(if4.c), 32'd0);
    checkOutput("rst carry_any", 32'(if4.carry_any), 32'd0);
    checkOutput("rst carry_cnt", 32'(if4.carry_cnt), 32'd0);
    checkOutput("rst w1 out_valid", 32'(if1.out_valid), 32'd0);
`ifdef HALF_ADDER_PARITY_EN
    checkOutput("rst parity", 32'(if4.parity), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready after reset", 32'(if4.in_ready), 32'd1);
  endtask

  // Reference result of one lane pair set, computed with per-lane integer addition.
  function automatic void refAdd(input logic [3:0] a, input logic [3:0] b,
                                 output logic [3:0] s, output logic [3:0] c);
    int sum;
    for (int i = 0; i < 4; i++) begin
      sum  = int'(a[i]) + int'(b[i]);
      s[i] = (sum % 2) != 0;
      c[i] = (sum / 2) != 0;
    end
  endfunction

  initial begin
    vec_t       tbl[5];
    logic [3:0] m_s, m_c, r_s, r_c;
    bit         m_valid, exp_ready, stalled;
    int         m_cnt;
    int         exp_sat[5];

    n_compared   = 0;
    n_mismatched = 0;

    tbl[0] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0, cnt: 0};
    tbl[1] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0, cnt: 0};
    tbl[2] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0, cnt: 0};
    tbl[3] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0, cnt: 0};
    tbl[4] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1, cnt: 1};
    exp_sat = '{1, 2, 3, 3, 3};

    doReset();

    $display("[TB] WIDTH=1 truth table, back-to-back");
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if1.in_valid  = 1'b1;
      if1.a         = tbl[i].a;
      if1.b         = tbl[i].b;
      if1.out_ready = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("w1 out_valid[%0d]", i), 32'(if1.out_valid), 32'd1);
      checkOutput($sformatf("w1 s[%0d]", i), 32'(if1.s), 32'(tbl[i].s));
      checkOutput($sformatf("w1 c[%0d]", i), 32'(if1.c), 32'(tbl[i].c));
      checkOutput($sformatf("w1 carry_any[%0d]", i), 32'(if1.carry_any), 32'(tbl[i].c));
      checkOutput($sformatf("w1 carry_cnt[%0d]", i), 32'(if1.carry_cnt), 32'(tbl[i].cnt));
    end
    if1.in_valid = 1'b0;

    $display("[TB] WIDTH=4 backpressure");
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall s", 32'(if4.s), 32'b0110);
      checkOutput("stall c", 32'(if4.c), 32'b1000);
      checkOutput("stall carry_any", 32'(if4.carry_any), 32'd1);
      checkOutput("stall out_valid", 32'(if4.out_valid), 32'd1);
      checkOutput("stall in_ready", 32'(if4.in_ready), 32'd0);
      @(negedge clk);
    end
    if4.out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(if4.in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("release s", 32'(if4.s), 32'b0000);
    checkOutput("release c", 32'(if4.c), 32'b0011);
    checkOutput("release carry_cnt", 32'(if4.carry_cnt), 32'd2);
    @(negedge clk);
    checkOutput("drain out_valid", 32'(if4.out_valid), 32'd0);

    $display("[TB] CNT_W=2 saturation and clear");
    doReset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("sat cnt[%0d]", i), 32'(if4.carry_cnt), 32'(exp_sat[i]));
    end
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("clear beats inc", 32'(if4.carry_cnt), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

    $display("[TB] reset during stall");
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 4'b1111, 4'b0101, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("pre-reset out_valid", 32'(if4.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", 32'(if4.out_valid), 32'd0);
    checkOutput("async rst s", 32'(if4.s), 32'd0);
    checkOutput("async rst c", 32'(if4.c), 32'd0);
    checkOutput("async rst carry_any", 32'(if4.carry_any), 32'd0);
    checkOutput("async rst carry_cnt", 32'(if4.carry_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 32'(if4.in_ready), 32'd1);

`ifdef HALF_ADDER_PARITY_EN
    $display("[TB] parity");
    @(negedge clk);
    applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("parity s", 32'(if4.s), 32'b0110);
    checkOutput("parity", 32'(if4.parity), 32'd0);
`endif

    $display("[TB] randomized traffic");
    doReset();
    m_valid = 1'b0;
    m_cnt   = 0;
    m_s     = '0;
    m_c     = '0;
    stalled = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      checkOutput("rnd out_valid", 32'(if4.out_valid), 32'(m_valid));
      checkOutput("rnd carry_cnt", 32'(if4.carry_cnt), 32'(m_cnt));
      if (m_valid) begin
        checkOutput("rnd s", 32'(if4.s), 32'(m_s));
        checkOutput("rnd c", 32'(if4.c), 32'(m_c));
        checkOutput("rnd carry_any", 32'(if4.carry_any), 32'(m_c != 4'd0));
`ifdef HALF_ADDER_PARITY_EN
        checkOutput("rnd parity", 32'(if4.parity), 32'($countones(m_s) % 2));
`endif
      end
      if (!stalled) begin
        if4.in_valid = ($urandom_range(0, 3) != 0);
        if4.a        = 4'($urandom);
        if4.b        = 4'($urandom);
      end
      if4.out_ready = ($urandom_range(0, 3) != 0);
      if4.cnt_clr   = ($urandom_range(0, 15) == 0);
      exp_ready     = !m_valid || if4.out_ready;
      #1;
      checkOutput("rnd in_ready", 32'(if4.in_ready), 32'(exp_ready));
      @(posedge clk);
      refAdd(if4.a, if4.b, r_s, r_c);
      if (if4.cnt_clr)
        m_cnt = 0;
      else if (if4.in_valid && exp_ready && r_c != 4'd0)
        m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
      stalled = if4.in_valid && !exp_ready;
      if (if4.in_valid && exp_ready) begin
        m_valid = 1'b1;
        m_s     = r_s;
        m_c     = r_c;
      end else if (if4.out_ready) begin
        m_valid = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
